// File: rtl/wino_layer_sequencer.sv
// Layer sequencer for the Winograd conv engine: walks every id slice and od lane group,
// handshaking tiles with the data controller and supplying indices to the weight controller.
module wino_layer_sequencer #(
    parameter int OD_LANES    = 2,
    parameter int OD_W        = 8,
    parameter int ID_W        = 4,
    parameter int START_DELAY = 4,
    parameter int PASS_W      = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_wen_i,
    input  logic [ID_W-1:0]     cfg_id_i,
    input  logic [OD_W-1:0]     cfg_od_i,
    input  logic                cfg_size_type_i,
    output logic                cfg_ready_o,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                data_ready_i,
    input  logic                data_complete_i,
    output logic                data_prepare_o,
    output logic                data_start_o,
    output logic [ID_W-1:0]     data_id_o,
    output logic                size_type_o,
    output logic [ID_W-1:0]     weight_id_o,
    output logic [OD_W-1:0]     weight_od_base_o,
    output logic [OD_LANES-1:0] weight_od_mask_o,
    output logic [PASS_W-1:0]   pass_count_o,
    output logic                busy_o,
    output logic                conv_completed_o,
    output logic                err_o
);
    localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [OD_W:0]      LANES_X  = (OD_W+1)'(OD_LANES);
    localparam logic [OD_W-1:0]    LANES_N  = OD_W'(OD_LANES);
    localparam logic [DLY_W-1:0]   DLY_INIT = DLY_W'(START_DELAY - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREPARE = 3'd1,
        ST_DELAY   = 3'd2,
        ST_RUN     = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Lane i is live when its od channel base+i lies inside the layer; computed without wrap.
    function automatic logic [OD_LANES-1:0] lane_mask(input logic [OD_W-1:0] base,
                                                       input logic [OD_W-1:0] total);
        logic [OD_LANES-1:0] m;
        m = {OD_LANES{1'b0}};
        for (int i = 0; i < OD_LANES; i++) begin
            m[i] = (({1'b0, base} + (OD_W+1)'(i)) < {1'b0, total});
        end
        return m;
    endfunction

    state_t              state_r, state_s;
    logic [ID_W-1:0]     cfg_id_r, id_r, id_s, eff_id_s;
    logic [OD_W-1:0]     cfg_od_r, base_r, base_s, eff_od_s;
    logic [OD_LANES-1:0] mask_r, mask_s;
    logic [PASS_W-1:0]   pass_r, pass_s;
    logic [DLY_W-1:0]    dly_r, dly_s;
    logic                size_r, start_r, start_s, err_r, err_s;
    logic                prepare_r, busy_r, done_r, cfg_ready_r;
    logic                cfg_take_s, start_ok_s, last_group_s, last_id_s;

    assign cfg_take_s   = cfg_wen_i & cfg_ready_r;
    assign eff_id_s     = cfg_take_s ? cfg_id_i : cfg_id_r;
    assign eff_od_s     = cfg_take_s ? cfg_od_i : cfg_od_r;
    assign start_ok_s   = start_i & ~abort_i & ((state_r == ST_IDLE) | (state_r == ST_DONE));
    assign last_group_s = (({1'b0, base_r} + LANES_X) >= {1'b0, cfg_od_r});
    assign last_id_s    = (id_r == (cfg_id_r - ID_W'(1)));
    // A stray completion outside RUN wins over the clear from a start in the same cycle.
    assign err_s        = (data_complete_i & (state_r != ST_RUN)) ? 1'b1 :
                          (start_ok_s ? 1'b0 : err_r);

    // Next-state, counter and start-pulse logic; abort overrides everything.
    always_comb begin
        state_s = state_r;
        id_s    = id_r;
        base_s  = base_r;
        mask_s  = mask_r;
        pass_s  = pass_r;
        dly_s   = dly_r;
        start_s = 1'b0;
        if (abort_i) begin
            state_s = ST_IDLE;
            id_s    = ID_W'(0);
            base_s  = OD_W'(0);
            mask_s  = OD_LANES'(0);
            pass_s  = PASS_W'(0);
            dly_s   = DLY_W'(0);
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        id_s   = ID_W'(0);
                        base_s = OD_W'(0);
                        pass_s = PASS_W'(0);
                        if ((eff_id_s == ID_W'(0)) || (eff_od_s == OD_W'(0))) begin
                            state_s = ST_DONE;
                            mask_s  = OD_LANES'(0);
                        end else begin
                            state_s = ST_PREPARE;
                            mask_s  = lane_mask(OD_W'(0), eff_od_s);
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_PREPARE: begin
                    if (data_ready_i) begin
                        state_s = ST_DELAY;
                        dly_s   = DLY_INIT;
                        start_s = (START_DELAY == 1);
                    end else begin
                        state_s = ST_PREPARE;
                    end
                end
                ST_DELAY: begin
                    // start_r is registered, so it is raised one cycle before dly reaches 0
                    if (dly_r == DLY_W'(0)) begin
                        state_s = ST_RUN;
                    end else begin
                        dly_s   = dly_r - DLY_W'(1);
                        start_s = (dly_r == DLY_W'(1));
                    end
                end
                ST_RUN: begin
                    if (data_complete_i) begin
                        state_s = ST_ADVANCE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_ADVANCE: begin
                    pass_s = (pass_r == {PASS_W{1'b1}}) ? pass_r : (pass_r + PASS_W'(1));
                    if (last_group_s && last_id_s) begin
                        state_s = ST_DONE;
                    end else if (last_group_s) begin
                        state_s = ST_PREPARE;
                        base_s  = OD_W'(0);
                        id_s    = id_r + ID_W'(1);
                        mask_s  = lane_mask(OD_W'(0), cfg_od_r);
                    end else begin
                        state_s = ST_PREPARE;
                        base_s  = base_r + LANES_N;
                        mask_s  = lane_mask(base_r + LANES_N, cfg_od_r);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters, config and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cfg_id_r    <= ID_W'(0);
            cfg_od_r    <= OD_W'(0);
            size_r      <= 1'b0;
            id_r        <= ID_W'(0);
            base_r      <= OD_W'(0);
            mask_r      <= OD_LANES'(0);
            pass_r      <= PASS_W'(0);
            dly_r       <= DLY_W'(0);
            start_r     <= 1'b0;
            err_r       <= 1'b0;
            prepare_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cfg_ready_r <= 1'b1;
        end else begin
            if (cfg_take_s) begin
                cfg_id_r <= cfg_id_i;
                cfg_od_r <= cfg_od_i;
                size_r   <= cfg_size_type_i;
            end
            state_r     <= state_s;
            id_r        <= id_s;
            base_r      <= base_s;
            mask_r      <= mask_s;
            pass_r      <= pass_s;
            dly_r       <= dly_s;
            start_r     <= start_s;
            err_r       <= err_s;
            prepare_r   <= (state_s == ST_PREPARE);
            done_r      <= (state_s == ST_DONE);
            cfg_ready_r <= (state_s == ST_IDLE) || (state_s == ST_DONE);
            busy_r      <= (state_s != ST_IDLE) && (state_s != ST_DONE);
        end
    end

    assign cfg_ready_o      = cfg_ready_r;
    assign data_prepare_o   = prepare_r;
    assign data_start_o     = start_r;
    assign data_id_o        = id_r;
    assign weight_id_o      = id_r;
    assign size_type_o      = size_r;
    assign weight_od_base_o = base_r;
    assign weight_od_mask_o = mask_r;
    assign pass_count_o     = pass_r;
    assign busy_o           = busy_r;
    assign conv_completed_o = done_r;
    assign err_o            = err_r;

endmodule

// File: tb/tb_wino_layer_sequencer.sv
// Randomized bench for wino_layer_sequencer: two instances (2 lanes/delay 4, 4 lanes/delay 1)
// checked against a pass-list model built directly from the layer dimensions.
module tb_wino_layer_sequencer;
    localparam int OD_W = 8, ID_W = 4, PASS_W = 12;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] cfg_wen, cfg_size, start, abort, dready, dcomp;
    logic [ID_W-1:0] cfg_id [2];
    logic [OD_W-1:0] cfg_od [2];
    wire  [1:0] cfg_ready, prep, dstart, size_t, busy, done, err;
    wire  [ID_W-1:0] did [2];
    wire  [ID_W-1:0] wid [2];
    wire  [OD_W-1:0] wbase [2];
    wire  [PASS_W-1:0] pcnt [2];
    wire  [1:0] mask0;
    wire  [3:0] mask1;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wino_layer_sequencer #(.OD_LANES(2), .OD_W(OD_W), .ID_W(ID_W), .START_DELAY(4), .PASS_W(PASS_W)) u_dut0 (
        .clk(clk), .reset(reset), .cfg_wen_i(cfg_wen[0]), .cfg_id_i(cfg_id[0]), .cfg_od_i(cfg_od[0]),
        .cfg_size_type_i(cfg_size[0]), .cfg_ready_o(cfg_ready[0]), .start_i(start[0]), .abort_i(abort[0]),
        .data_ready_i(dready[0]), .data_complete_i(dcomp[0]), .data_prepare_o(prep[0]),
        .data_start_o(dstart[0]), .data_id_o(did[0]), .size_type_o(size_t[0]), .weight_id_o(wid[0]),
        .weight_od_base_o(wbase[0]), .weight_od_mask_o(mask0), .pass_count_o(pcnt[0]),
        .busy_o(busy[0]), .conv_completed_o(done[0]), .err_o(err[0]));

    wino_layer_sequencer #(.OD_LANES(4), .OD_W(OD_W), .ID_W(ID_W), .START_DELAY(1), .PASS_W(PASS_W)) u_dut1 (
        .clk(clk), .reset(reset), .cfg_wen_i(cfg_wen[1]), .cfg_id_i(cfg_id[1]), .cfg_od_i(cfg_od[1]),
        .cfg_size_type_i(cfg_size[1]), .cfg_ready_o(cfg_ready[1]), .start_i(start[1]), .abort_i(abort[1]),
        .data_ready_i(dready[1]), .data_complete_i(dcomp[1]), .data_prepare_o(prep[1]),
        .data_start_o(dstart[1]), .data_id_o(did[1]), .size_type_o(size_t[1]), .weight_id_o(wid[1]),
        .weight_od_base_o(wbase[1]), .weight_od_mask_o(mask1), .pass_count_o(pcnt[1]),
        .busy_o(busy[1]), .conv_completed_o(done[1]), .err_o(err[1]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lanes(input int k);
        return (k == 1) ? 4 : 2;
    endfunction

    function automatic int delay_of(input int k);
        return (k == 1) ? 1 : 4;
    endfunction

    function automatic logic [3:0] get_mask(input int k);
        return (k == 1) ? mask1 : {2'b00, mask0};
    endfunction

    task automatic wait_prepare(input int k);
        int n;
        n = 0;
        while (!prep[k] && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("prepare_wait", prep[k], 1);
    endtask

    // kind: 0 plain, 1 abort in DELAY, 2 stray complete in PREPARE, 3 cfg write while busy, 4 reset in RUN
    task automatic run_layer(input int k, input int tid, input int tod, input int kind, input int at_pass);
        int exp_id[$];
        int exp_base[$];
        int exp_mask[$];
        int lw, dl, np, first, highs, sz;
        lw = lanes(k);
        dl = delay_of(k);
        for (int i = 0; i < tid; i++) begin
            for (int b = 0; b < tod; b += lw) begin
                int m;
                m = 0;
                for (int j = 0; j < lw; j++) if (b + j < tod) m |= (1 << j);
                exp_id.push_back(i);
                exp_base.push_back(b);
                exp_mask.push_back(m);
            end
        end
        np = exp_id.size();
        sz = $urandom_range(0, 1);
        @(negedge clk);
        cfg_wen[k] = 1'b1; start[k] = 1'b1;
        cfg_id[k] = ID_W'(tid); cfg_od[k] = OD_W'(tod); cfg_size[k] = sz[0];
        @(negedge clk);
        cfg_wen[k] = 1'b0; start[k] = 1'b0;
        check("err_cleared_by_start", err[k], 0);
        if (np == 0) begin
            check("empty_done", done[k], 1);
            check("empty_busy", busy[k], 0);
            check("empty_cfg_ready", cfg_ready[k], 1);
            return;
        end
        check("done_dropped", done[k], 0);
        check("busy_run", busy[k], 1);
        check("cfg_ready_run", cfg_ready[k], 0);
        check("size_type", size_t[k], sz);
        for (int p = 0; p < np; p++) begin
            wait_prepare(k);
            check("id", did[k], exp_id[p]);
            check("weight_id", wid[k], exp_id[p]);
            check("base", wbase[k], exp_base[p]);
            check("mask", get_mask(k), exp_mask[p]);
            if (kind == 2 && p == at_pass) begin
                dcomp[k] = 1'b1;
                @(negedge clk);
                dcomp[k] = 1'b0;
                check("err_set", err[k], 1);
                check("prepare_kept", prep[k], 1);
                check("pass_kept", pcnt[k], p);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            dready[k] = 1'b1;
            first = 0;
            highs = 0;
            for (int c = 1; c <= dl + 3; c++) begin
                @(negedge clk);
                dready[k] = 1'b0;
                if (dstart[k]) begin
                    highs++;
                    if (first == 0) first = c;
                end
                if (kind == 1 && p == at_pass && c == 2) begin
                    abort[k] = 1'b1;
                    @(negedge clk);
                    abort[k] = 1'b0;
                    check("abort_busy", busy[k], 0);
                    check("abort_pass", pcnt[k], 0);
                    check("abort_cfg_ready", cfg_ready[k], 1);
                    repeat (4) @(negedge clk) if (dstart[k]) highs++;
                    check("abort_no_start", highs, 0);
                    return;
                end
            end
            check("start_latency", first, dl);
            check("start_once", highs, 1);
            check("id_stable_run", did[k], exp_id[p]);
            check("base_stable_run", wbase[k], exp_base[p]);
            if (kind == 3 && p == at_pass) begin
                cfg_wen[k] = 1'b1; cfg_id[k] = ID_W'(0); cfg_od[k] = OD_W'(0);
                @(negedge clk);
                cfg_wen[k] = 1'b0;
            end
            if (kind == 4 && p == at_pass) begin
                reset = 1'b0;
                #1;
                check("rst_busy", busy[k], 0);
                check("rst_pass", pcnt[k], 0);
                check("rst_id", did[k], 0);
                check("rst_base", wbase[k], 0);
                check("rst_mask", get_mask(k), 0);
                check("rst_err", err[k], 0);
                check("rst_size", size_t[k], 0);
                check("rst_cfg_ready", cfg_ready[k], 1);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            dcomp[k] = 1'b1;
            @(negedge clk);
            dcomp[k] = 1'b0;
            @(negedge clk);
            check("pass_count", pcnt[k], p + 1);
        end
        check("layer_done", done[k], 1);
        check("layer_idle_busy", busy[k], 0);
        check("layer_cfg_ready", cfg_ready[k], 1);
        if (kind == 2) check("err_sticky", err[k], 1);
    endtask

    initial begin
        reset = 1'b0;
        cfg_wen = 2'b00; cfg_size = 2'b00; start = 2'b00; abort = 2'b00; dready = 2'b00; dcomp = 2'b00;
        for (int k = 0; k < 2; k++) begin
            cfg_id[k] = ID_W'(0);
            cfg_od[k] = OD_W'(0);
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_cfg_ready", cfg_ready[k], 1);
            check("reset_busy", busy[k], 0);
            check("reset_done", done[k], 0);
            check("reset_pass", pcnt[k], 0);
            check("reset_err", err[k], 0);
            check("reset_prepare", prep[k], 0);
            check("reset_start", dstart[k], 0);
        end
        reset = 1'b1;
        @(negedge clk);
        run_layer(0, 2, 0, 0, 0);
        run_layer(0, 2, 4, 2, 0);
        run_layer(1, 1, 6, 0, 0);
        run_layer(0, 2, 4, 1, 1);
        run_layer(0, 2, 4, 0, 0);
        run_layer(1, 2, 5, 3, 0);
        for (int r = 0; r < 10; r++) begin
            run_layer(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), 0, 0);
        end
        run_layer(0, 3, 6, 2, 0);
        run_layer(0, 3, 6, 4, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
